// File: rtl/clk_wiz.sv
// Phase-accumulator pixel-clock generator: derives clk_out1 = f_in * PHASE_INC / 2^ACC_W
// from clk_in1, gated glitch-free until the lock counter expires.
module clk_wiz #(
  parameter int unsigned     ACC_W       = 32,
  parameter longint unsigned PHASE_INC   = 64'h4000_0000,
  parameter int unsigned     LOCK_CYCLES = 16
) (
  input  logic clk_in1,
  input  logic reset,
  output logic clk_out1,
  output logic clk_en1,
  output logic locked
);

  localparam int unsigned     CNT_W   = $clog2(LOCK_CYCLES + 1);
  localparam longint unsigned INC_MAX = 64'd1 << (ACC_W - 1);
  localparam logic [ACC_W-1:0] INC    = ACC_W'(PHASE_INC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

  if (ACC_W < 2 || ACC_W > 63) begin : g_bad_acc_w
    $error("clk_wiz: ACC_W must be in 2..63");
  end
  if (PHASE_INC < 1 || PHASE_INC > INC_MAX) begin : g_bad_phase_inc
    $error("clk_wiz: PHASE_INC must be in 1 .. 2^(ACC_W-1)");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock_cycles
    $error("clk_wiz: LOCK_CYCLES must be at least 1");
  end

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_lock_cnt;
  logic             r_run;
  logic             r_clk_out;
  logic             r_clk_en;
  logic             r_locked;

  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_msb_new;
  logic             w_run_next;

  always_comb begin
    w_acc_next = r_acc + INC;
    w_msb_new  = w_acc_next[ACC_W-1];
    w_cnt_next = (r_lock_cnt == CNT_MAX) ? r_lock_cnt : r_lock_cnt + 1'b1;
    // Gate opens only in a low phase so the first high pulse is never a runt.
    w_run_next = r_run | (r_locked & ~w_msb_new);
  end

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_acc      <= '0;
      r_lock_cnt <= '0;
      r_run      <= 1'b0;
      r_clk_out  <= 1'b0;
      r_clk_en   <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_acc      <= w_acc_next;
      r_lock_cnt <= w_cnt_next;
      r_run      <= w_run_next;
      r_clk_out  <= w_msb_new & w_run_next;
      r_clk_en   <= w_msb_new & w_run_next & ~r_clk_out;
      r_locked   <= r_locked | (w_cnt_next == CNT_MAX);
    end
  end

  assign clk_out1 = r_clk_out;
  assign clk_en1  = r_clk_en;
  assign locked   = r_locked;

endmodule

// File: tb/tb_clk_wiz.sv
// Directed bench for clk_wiz: default f_in/4, f_in/2 with LOCK_CYCLES=1, and 3/16 fractional rate.
module tb_clk_wiz;

  logic clk_in1 = 1'b0;
  logic reset   = 1'b1;

  logic d_out, d_en, d_lock;
  logic h_out, h_en, h_lock;
  logic f_out, f_en, f_lock;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in1 = ~clk_in1;

  clk_wiz u_def (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .clk_out1 (d_out),
    .clk_en1  (d_en),
    .locked   (d_lock)
  );

  clk_wiz #(
    .PHASE_INC   (64'h8000_0000),
    .LOCK_CYCLES (1)
  ) u_div2 (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .clk_out1 (h_out),
    .clk_en1  (h_en),
    .locked   (h_lock)
  );

  clk_wiz #(
    .PHASE_INC (64'h3000_0000)
  ) u_frac (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .clk_out1 (f_out),
    .clk_en1  (f_en),
    .locked   (f_lock)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in1);
    #1;
  endtask

  // Checks edges k=1..last_k after a reset release, expected values from closed-form timing.
  task automatic run_seq(input int last_k);
    logic eo, ee, el;
    for (int k = 1; k <= last_k; k++) begin
      tick();
      el = (k >= 16);
      eo = (k >= 18) && ((k % 4) >= 2);
      ee = (k >= 18) && ((k % 4) == 2);
      check_eq($sformatf("def k=%0d {out,en,lock}", k), {29'd0, d_out, d_en, d_lock},
               {29'd0, eo, ee, el});
      el = 1'b1;
      eo = (k >= 3) && ((k % 2) == 1);
      check_eq($sformatf("div2 k=%0d {out,en,lock}", k), {29'd0, h_out, h_en, h_lock},
               {29'd0, eo, eo, el});
    end
  endtask

  initial begin
    int  pulses;
    int  run_len;
    int  min_len;
    int  max_len;
    bit  found;
    logic prev;

    reset = 1'b1;
    repeat (3) tick();
    check_eq("reset state", {23'd0, d_out, d_en, d_lock, h_out, h_en, h_lock, f_out, f_en, f_lock},
             32'd0);
    reset = 1'b0;

    run_seq(30);
    check_eq("clk_out1 high before mid reset", {31'd0, d_out}, 32'd1);

    // Mid-operation reset, then hold it for 100 edges.
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      check_eq($sformatf("hold i=%0d all outputs", i),
               {23'd0, d_out, d_en, d_lock, h_out, h_en, h_lock, f_out, f_en, f_lock}, 32'd0);
    end
    reset = 1'b0;

    run_seq(32);

    // Fractional rate: align on a rising edge, then count pulses and phase widths.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (f_en) found = 1'b1;
    end
    check_eq("frac first enable seen", {31'd0, found}, 32'd1);
    if (found) begin
      pulses  = 0;
      run_len = 1;
      min_len = 1000;
      max_len = 0;
      prev    = f_out;
      for (int i = 0; i < 65536; i++) begin
        tick();
        if (f_en) pulses++;
        if (f_out == prev) begin
          run_len++;
        end else begin
          if (run_len < min_len) min_len = run_len;
          if (run_len > max_len) max_len = run_len;
          run_len = 1;
        end
        prev = f_out;
      end
      // 65536 * 3/16 = 12288 pulses, +-1 for window alignment.
      check_eq("frac pulse count in range", {31'd0, (pulses >= 12287 && pulses <= 12289)},
               32'd1);
      if (!(pulses >= 12287 && pulses <= 12289))
        $display("FAIL frac pulse count: got %0d expected 12288+-1", pulses);
      check_eq("frac min phase >= 2", {31'd0, (min_len >= 2)}, 32'd1);
      check_eq("frac max phase <= 3", {31'd0, (max_len <= 3)}, 32'd1);
      check_eq("frac locked", {31'd0, f_lock}, 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
